// File: rtl/stream_demux_1to2_pkg.sv
// Shared types for the stream demux slice.
// Holds the 2-entry occupancy encoding used by the FIFO elements.
package stream_demux_1to2_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

    function automatic occ_t occ_next(occ_t occ, logic push, logic pop);
        occ_t r;
        unique case ({push, pop})
            2'b10:   r = occ + 2'd1;
            2'b01:   r = occ - 2'd1;
            default: r = occ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_1to2_if.sv
// Valid/ready stream bundle.
// sel only carries meaning on the demux input side.
interface stream_demux_1to2_if #(
    parameter int DATA_W = 8
) ();

    logic              valid;
    logic              ready;
    logic              sel;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, output sel, input ready);
    modport slave  (input valid, input data, input sel, output ready);

endinterface

// File: rtl/stream_demux_1to2_fifo2.sv
// Two-entry registered valid/ready FIFO with a delivered-beat counter.
// Output payload comes straight from storage, so it is stable under stall.
module stream_demux_1to2_fifo2
    import stream_demux_1to2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              full_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    occ_t              occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (occ_q == OCC_FULL);
    assign valid_o = (occ_q != OCC_EMPTY);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = valid_o && ready_i;

    // Next-state: write at wr_ptr, read at rd_ptr, count each pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        occ_d    = occ_next(occ_q, do_push, do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any buffered beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= OCC_EMPTY;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_demux_1to2.sv
// 1-to-2 stream demux: steers each input beat to out0/out1 by sel.
// Ready looks only at the selected buffer's registered fullness.
module stream_demux_1to2
    import stream_demux_1to2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_1to2_if.slave  in_if,
    stream_demux_1to2_if.master out0_if,
    stream_demux_1to2_if.master out1_if,
    output logic [CNT_W-1:0]    out0_count,
    output logic [CNT_W-1:0]    out1_count
);

    logic full0;
    logic full1;
    logic rdy;
    logic acc;

    // Ready mux: selected buffer must have a free slot.
    always_comb begin
        rdy = 1'b0;
        unique case (in_if.sel)
            1'b0:    rdy = !full0;
            1'b1:    rdy = !full1;
            default: rdy = 1'b0;
        endcase
    end

    assign in_if.ready = rdy;
    assign acc         = in_if.valid && rdy;
    assign out0_if.sel = 1'b0;
    assign out1_if.sel = 1'b1;

    stream_demux_1to2_fifo2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (acc && !in_if.sel),
        .push_data_i (in_if.data),
        .full_o      (full0),
        .valid_o     (out0_if.valid),
        .ready_i     (out0_if.ready),
        .data_o      (out0_if.data),
        .count_o     (out0_count)
    );

    stream_demux_1to2_fifo2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_fifo1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (acc && in_if.sel),
        .push_data_i (in_if.data),
        .full_o      (full1),
        .valid_o     (out1_if.valid),
        .ready_i     (out1_if.ready),
        .data_o      (out1_if.data),
        .count_o     (out1_count)
    );

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2.
// Instance a uses CNT_W=16, instance b uses CNT_W=4 for wrap.
module tb_stream_demux_1to2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    stream_demux_1to2_if #(.DATA_W(8)) in_a ();
    stream_demux_1to2_if #(.DATA_W(8)) o0_a ();
    stream_demux_1to2_if #(.DATA_W(8)) o1_a ();
    stream_demux_1to2_if #(.DATA_W(8)) in_b ();
    stream_demux_1to2_if #(.DATA_W(8)) o0_b ();
    stream_demux_1to2_if #(.DATA_W(8)) o1_b ();

    logic [15:0] cnt0_a, cnt1_a;
    logic [3:0]  cnt0_b, cnt1_b;

    stream_demux_1to2 #(.DATA_W(8), .CNT_W(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_a),
        .out0_if    (o0_a),
        .out1_if    (o1_a),
        .out0_count (cnt0_a),
        .out1_count (cnt1_a)
    );

    stream_demux_1to2 #(.DATA_W(8), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_if      (in_b),
        .out0_if    (o0_b),
        .out1_if    (o1_b),
        .out0_count (cnt0_b),
        .out1_count (cnt1_b)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_a.valid = 0; in_a.sel = 0; in_a.data = 0;
        o0_a.ready = 0; o1_a.ready = 0;
        in_b.valid = 0; in_b.sel = 0; in_b.data = 0;
        o0_b.ready = 0; o1_b.ready = 0;
        cyc(); cyc();
        total++;
        if (o0_a.valid !== 1'b0 || o1_a.valid !== 1'b0 || o0_a.data !== 8'h00 || cnt0_a !== 16'd0) $display("FAIL reset_hold got v0=%b v1=%b d0=%h c0=%0d exp 0 0 00 0", o0_a.valid, o1_a.valid, o0_a.data, cnt0_a);
        else passed++;
        rst_n = 1;
        cyc();
        total++;
        if (in_a.ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", in_a.ready);
        else passed++;
        // one delivered beat so the counter has something to clear
        o0_a.ready = 1;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'hE0;
        cyc();
        in_a.valid = 0;
        cyc();
        total++;
        if (cnt0_a !== 16'd1) $display("FAIL reset_precount got %0d exp 1", cnt0_a);
        else passed++;
        // fill both buffers
        o0_a.ready = 0;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'hF0; cyc();
        in_a.data = 8'hF1; cyc();
        in_a.sel = 1; in_a.data = 8'hF2; cyc();
        in_a.data = 8'hF3; cyc();
        in_a.valid = 0;
        total++;
        if (o0_a.valid !== 1'b1 || o1_a.valid !== 1'b1 || in_a.ready !== 1'b0) $display("FAIL reset_full got v0=%b v1=%b rdy=%b exp 1 1 0", o0_a.valid, o1_a.valid, in_a.ready);
        else passed++;
        #2 rst_n = 0;
        #1;
        total++;
        if (o0_a.valid !== 1'b0 || o1_a.valid !== 1'b0 || cnt0_a !== 16'd0 || o0_a.data !== 8'h00 || o1_a.data !== 8'h00) $display("FAIL reset_async got v0=%b v1=%b c0=%0d d0=%h d1=%h exp 0 0 0 00 00", o0_a.valid, o1_a.valid, cnt0_a, o0_a.data, o1_a.data);
        else passed++;
        cyc();
        #3 rst_n = 1;
        cyc();
        total++;
        if (in_a.ready !== 1'b1 || o0_a.valid !== 1'b0 || o1_a.valid !== 1'b0 || cnt0_a !== 16'd0 || cnt1_a !== 16'd0) $display("FAIL reset_after got rdy=%b v0=%b v1=%b c0=%0d c1=%0d exp 1 0 0 0 0", in_a.ready, o0_a.valid, o1_a.valid, cnt0_a, cnt1_a);
        else passed++;
    endtask

    task automatic test_routing();
        o0_a.ready = 1; o1_a.ready = 1;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'hA1;
        cyc();
        total++;
        if (o0_a.valid !== 1'b1 || o0_a.data !== 8'hA1 || o1_a.valid !== 1'b0) $display("FAIL route_out0 got v0=%b d0=%h v1=%b exp 1 a1 0", o0_a.valid, o0_a.data, o1_a.valid);
        else passed++;
        in_a.sel = 1; in_a.data = 8'hB2;
        cyc();
        total++;
        if (o1_a.valid !== 1'b1 || o1_a.data !== 8'hB2 || o0_a.valid !== 1'b0) $display("FAIL route_out1 got v1=%b d1=%h v0=%b exp 1 b2 0", o1_a.valid, o1_a.data, o0_a.valid);
        else passed++;
        in_a.valid = 0;
        cyc();
        total++;
        if (cnt0_a !== 16'd1 || cnt1_a !== 16'd1 || o1_a.valid !== 1'b0) $display("FAIL route_counts got c0=%0d c1=%0d v1=%b exp 1 1 0", cnt0_a, cnt1_a, o1_a.valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        o0_a.ready = 0;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'h11;
        cyc();
        in_a.data = 8'h22;
        cyc();
        in_a.data = 8'h33;
        total++;
        if (in_a.ready !== 1'b0) $display("FAIL bp_third_ready got %b exp 0", in_a.ready);
        else passed++;
        cyc();
        total++;
        if (o0_a.valid !== 1'b1 || o0_a.data !== 8'h11 || in_a.ready !== 1'b0) $display("FAIL bp_hold got v0=%b d0=%h rdy=%b exp 1 11 0", o0_a.valid, o0_a.data, in_a.ready);
        else passed++;
        o0_a.ready = 1;
        total++;
        if (in_a.ready !== 1'b0) $display("FAIL bp_no_comb_path got %b exp 0", in_a.ready);
        else passed++;
        cyc();
        total++;
        if (o0_a.data !== 8'h22 || in_a.ready !== 1'b1) $display("FAIL bp_second got d0=%h rdy=%b exp 22 1", o0_a.data, in_a.ready);
        else passed++;
        cyc();
        in_a.valid = 0;
        total++;
        if (o0_a.valid !== 1'b1 || o0_a.data !== 8'h33) $display("FAIL bp_third got v0=%b d0=%h exp 1 33", o0_a.valid, o0_a.data);
        else passed++;
        cyc();
        total++;
        if (o0_a.valid !== 1'b0 || cnt0_a !== 16'd4) $display("FAIL bp_count got v0=%b c0=%0d exp 0 4", o0_a.valid, cnt0_a);
        else passed++;
    endtask

    task automatic test_head_of_line();
        o0_a.ready = 0; o1_a.ready = 1;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'h44; cyc();
        in_a.data = 8'h55; cyc();
        in_a.data = 8'h66;
        total++;
        if (in_a.ready !== 1'b0 || o1_a.valid !== 1'b0) $display("FAIL hol_stall got rdy=%b v1=%b exp 0 0", in_a.ready, o1_a.valid);
        else passed++;
        cyc(); cyc();
        total++;
        if (in_a.ready !== 1'b0 || o0_a.data !== 8'h44 || o1_a.valid !== 1'b0) $display("FAIL hol_still got rdy=%b d0=%h v1=%b exp 0 44 0", in_a.ready, o0_a.data, o1_a.valid);
        else passed++;
        o0_a.ready = 1;
        cyc();
        total++;
        if (in_a.ready !== 1'b1 || o0_a.data !== 8'h55) $display("FAIL hol_release got rdy=%b d0=%h exp 1 55", in_a.ready, o0_a.data);
        else passed++;
        cyc();
        in_a.valid = 0;
        total++;
        if (o0_a.data !== 8'h66 || o0_a.valid !== 1'b1) $display("FAIL hol_last got v0=%b d0=%h exp 1 66", o0_a.valid, o0_a.data);
        else passed++;
        cyc();
        total++;
        if (cnt0_a !== 16'd7 || o0_a.valid !== 1'b0) $display("FAIL hol_count got c0=%0d v0=%b exp 7 0", cnt0_a, o0_a.valid);
        else passed++;
    endtask

    task automatic test_dual_pop();
        o0_a.ready = 0; o1_a.ready = 0;
        in_a.valid = 1; in_a.sel = 0; in_a.data = 8'h77; cyc();
        in_a.sel = 1; in_a.data = 8'h88; cyc();
        in_a.valid = 0;
        total++;
        if (o0_a.data !== 8'h77 || o1_a.data !== 8'h88 || o0_a.valid !== 1'b1 || o1_a.valid !== 1'b1) $display("FAIL dual_data got d0=%h d1=%h exp 77 88", o0_a.data, o1_a.data);
        else passed++;
        o0_a.ready = 1; o1_a.ready = 1;
        cyc();
        total++;
        if (cnt0_a !== 16'd8 || cnt1_a !== 16'd2 || o0_a.valid !== 1'b0 || o1_a.valid !== 1'b0) $display("FAIL dual_count got c0=%0d c1=%0d exp 8 2", cnt0_a, cnt1_a);
        else passed++;
    endtask

    task automatic test_throughput();
        o0_a.ready = 1;
        in_a.valid = 1; in_a.sel = 0;
        for (int i = 0; i < 100; i++) begin
            in_a.data = 8'(i);
            cyc();
            total++;
            if (o0_a.valid !== 1'b1 || o0_a.data !== 8'(i)) $display("FAIL thru_beat%0d got v0=%b d0=%h exp 1 %h", i, o0_a.valid, o0_a.data, 8'(i));
            else passed++;
        end
        in_a.valid = 0;
        cyc();
        total++;
        if (cnt0_a !== 16'd108) $display("FAIL thru_count got %0d exp 108", cnt0_a);
        else passed++;
    endtask

    task automatic test_wrap();
        o1_b.ready = 1;
        in_b.valid = 1; in_b.sel = 1;
        for (int i = 0; i < 17; i++) begin
            in_b.data = 8'(i + 8'h40);
            cyc();
        end
        in_b.valid = 0;
        cyc();
        total++;
        if (cnt1_b !== 4'd1 || cnt0_b !== 4'd0) $display("FAIL wrap_count got c1=%0d c0=%0d exp 1 0", cnt1_b, cnt0_b);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_head_of_line();
        test_dual_pop();
        test_throughput();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
